// File: rtl/braun_mul8_seq_if.sv
// braun_mul8_seq_if: requester handshake plus 4x4 core nibble/product bus for braun_mul8_seq
interface braun_mul8_seq_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    modport slave (input start, a, b, mul_p, output busy, done, p, mul_a, mul_b);
    modport master (output start, a, b, mul_p, input busy, done, p, mul_a, mul_b);
endinterface

// File: rtl/braun_mul8_seq.sv
// braun_mul8_seq: 8x8 unsigned multiply over four cycles through one external 4x4 core
module braun_mul8_seq (
    input logic            clk,
    input logic            rst,
    braun_mul8_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  ra_q, ra_d, rb_q, rb_d;
    logic [15:0] acc_q, acc_d, p_q, p_d, part, sum;
    // step[0] selects the high nibble of a, step[1] the high nibble of b
    assign bus.mul_a = (state_q == RUN) ? (step_q[0] ? ra_q[7:4] : ra_q[3:0]) : 4'd0;
    assign bus.mul_b = (state_q == RUN) ? (step_q[1] ? rb_q[7:4] : rb_q[3:0]) : 4'd0;
    assign part = (step_q == 2'd0) ? {8'd0, bus.mul_p} :
                  (step_q == 2'd3) ? {bus.mul_p, 8'd0} : {4'd0, bus.mul_p, 4'd0};
    assign sum = acc_q + part;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.p = p_q;
    always_comb begin
        state_d = state_q;
        step_d = step_q;
        ra_d = ra_q;
        rb_d = rb_q;
        acc_d = acc_q;
        p_d = p_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = bus.start ? RUN : IDLE;
                if (bus.start) begin
                    ra_d = bus.a;
                    rb_d = bus.b;
                    acc_d = 16'd0;
                    step_d = 2'd0;
                end
            end
            RUN: begin
                acc_d = sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    p_d = sum;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q <= 2'd0;
            ra_q <= 8'd0;
            rb_q <= 8'd0;
            acc_q <= 16'd0;
            p_q <= 16'd0;
        end else begin
            state_q <= state_d;
            step_q <= step_d;
            ra_q <= ra_d;
            rb_q <= rb_d;
            acc_q <= acc_d;
            p_q <= p_d;
        end
    end
endmodule

// File: tb/tb_braun_mul8_seq.sv
// tb_braun_mul8_seq: directed stimulus with a queue scoreboard checked by an independent done monitor
module tb_braun_mul8_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] p_hold = 16'd0;
    logic rst_prev = 1'b1;
    logic done_prev = 1'b0;

    braun_mul8_seq_if bus ();
    braun_mul8_seq dut (.clk(clk), .rst(rst), .bus(bus));

    // behavioural stand-in for the external combinational 4x4 core
    assign bus.mul_p = bus.mul_a * bus.mul_b;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done_prev) chk("done_not_consecutive", {15'd0, bus.done}, 16'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done with p=0x%04h expected no done at %0t", bus.p, $time);
                end else begin
                    chk("product", bus.p, exp_q.pop_front());
                end
            end else if (!rst_prev) begin
                chk("p_hold", bus.p, p_hold);
            end
        end
        p_hold <= bus.p;
        rst_prev <= rst;
        done_prev <= bus.done && !rst;
    end

    task automatic timed_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] e);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = ta;
        bus.b = tb;
        exp_q.push_back(e);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (k < 5) begin
                chk($sformatf("busy_s%0d", k - 1), {15'd0, bus.busy}, 16'd1);
                chk($sformatf("done_s%0d", k - 1), {15'd0, bus.done}, 16'd0);
                chk($sformatf("mul_a_s%0d", k - 1), {12'd0, bus.mul_a}, {12'd0, (k % 2 == 0) ? ta[7:4] : ta[3:0]});
                chk($sformatf("mul_b_s%0d", k - 1), {12'd0, bus.mul_b}, {12'd0, (k > 2) ? tb[7:4] : tb[3:0]});
            end else if (k == 5) begin
                chk("busy_done_cycle", {15'd0, bus.busy}, 16'd0);
                chk("done_at_n5", {15'd0, bus.done}, 16'd1);
            end else begin
                chk("done_one_cycle", {15'd0, bus.done}, 16'd0);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {15'd0, bus.busy}, 16'd0);
    endtask

    task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] e, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        bus.start = 1'b1;
        bus.a = ta;
        bus.b = tb;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("op_complete");
    endtask

    logic [7:0]  va[6] = '{8'h07, 8'h10, 8'hC8, 8'h01, 8'hAB, 8'h80};
    logic [7:0]  vb[6] = '{8'h09, 8'h10, 8'h64, 8'hFF, 8'hCD, 8'h80};
    logic [15:0] vp[6] = '{16'h003F, 16'h0100, 16'h4E20, 16'h00FF, 16'h88EF, 16'h4000};
    int          vg[6] = '{0, 1, 3, 2, 0, 1};

    initial begin
        bus.start = 1'b0;
        bus.a = 8'd0;
        bus.b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);
        chk("rst_p", bus.p, 16'd0);
        chk("rst_mul_a", {12'd0, bus.mul_a}, 16'd0);
        chk("rst_mul_b", {12'd0, bus.mul_b}, 16'd0);

        timed_op(8'h12, 8'h34, 16'h03A8);
        timed_op(8'hFF, 8'hFF, 16'hFE01);
        timed_op(8'hA5, 8'h00, 16'h0000);

        // start during step 1 with new operands must be ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'h22; bus.b = 8'h11;
        exp_q.push_back(16'h0242);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'hAB; bus.b = 8'hCD;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("ignored_start_complete");
        repeat (8) begin @(posedge clk); #1; end
        chk("ignored_start_no_rerun", {15'd0, bus.busy}, 16'd0);

        // start held high, new operands presented in the DONE cycle
        bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h10;
        exp_q.push_back(16'h00F0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                chk("b2b_done1", {15'd0, bus.done}, 16'd1);
                bus.a = 8'h80; bus.b = 8'h02;
                exp_q.push_back(16'h0100);
            end
            if (k == 6) begin
                chk("b2b_busy_n6", {15'd0, bus.busy}, 16'd1);
                bus.start = 1'b0;
            end
            if (k == 10) chk("b2b_done2", {15'd0, bus.done}, 16'd1);
        end

        // reset during step 2 aborts without a done pulse
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'hC8; bus.b = 8'h64;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {15'd0, bus.busy}, 16'd0);
        chk("abort_done", {15'd0, bus.done}, 16'd0);
        chk("abort_p", bus.p, 16'd0);
        chk("abort_mul_a", {12'd0, bus.mul_a}, 16'd0);
        chk("abort_mul_b", {12'd0, bus.mul_b}, 16'd0);
        op(8'h03, 8'h05, 16'h000F, 1);

        for (int i = 0; i < 6; i++) op(va[i], vb[i], vp[i], vg[i]);

        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size() > 0 ? 16'd1 : 16'd0, 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
